// File: rtl/imul_sched_pkg.sv
// imul_sched shared types and widths.
// Imported by the interface, the arbiter and the controller.
package imul_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RESP
    } state_t;

    localparam int IMUL_W   = 16;
    localparam int PROD_W   = 32;
    localparam int MAX_NREQ = 8;

    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/imul_sched_if.sv
// Request/response bundle between the clients and imul_sched.
// master = client side, slave = the scheduler.
interface imul_sched_if
    import imul_sched_pkg::*;
#(
    parameter int NREQ = 2
) ();

    localparam int IDW = idw(NREQ);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [IMUL_W*NREQ-1:0] req_a;
    logic [IMUL_W*NREQ-1:0] req_b;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [IDW-1:0]         rsp_id;
    logic [PROD_W-1:0]      rsp_data;
    logic                   busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, busy
    );

endinterface

// File: rtl/imul.sv
// Shared 16x16 unsigned combinational array multiplier.
// Output ripples; callers must hold A/B for the settle window.
module IMUL (
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [31:0] O
);

    assign O = {16'b0, A} * {16'b0, B};

endmodule

// File: rtl/imul_sched_arb.sv
// Requester arbiter: fixed priority, or round-robin when
// IMUL_SCHED_RR_EN is defined.
module imul_sched_arb
    import imul_sched_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic            Clock,
    input  logic            Reset_n,
    input  logic [NREQ-1:0] req_valid,
    input  logic            en,
    input  logic            accept,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx
);

    logic hit;

`ifdef IMUL_SCHED_RR_EN
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  start;
    logic [NREQ-1:0] rot;
    logic [IDW:0]    sum;

    // Rotate so the search begins one past the last winner.
    always_comb begin
        start = (ptr == IDW'(NREQ-1)) ? '0 : ptr + 1'b1;
        rot   = NREQ'({req_valid, req_valid} >> start);
        hit   = 1'b0;
        sum   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!hit && rot[i]) begin
                hit = 1'b1;
                sum = {1'b0, start} + (IDW+1)'(i);
            end
        end
        if (sum >= (IDW+1)'(NREQ))
            sum = sum - (IDW+1)'(NREQ);
        idx = sum[IDW-1:0];
        gnt = (en && hit) ? (NREQ'(1) << idx) : '0;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n)
            ptr <= IDW'(NREQ-1);
        else if (accept)
            ptr <= idx;
    end
`else
    logic unused_arb;

    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!hit && req_valid[i]) begin
                hit = 1'b1;
                idx = IDW'(i);
            end
        end
        gnt = (en && hit) ? (NREQ'(1) << idx) : '0;
    end

    assign unused_arb = ^{Clock, Reset_n, accept};
`endif

endmodule

// File: rtl/imul_sched.sv
// Arbitrating sequencer for the shared IMUL array.
// Define IMUL_SCHED_RR_EN for round-robin grant order.
module imul_sched
    import imul_sched_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int SETTLE = 3
) (
    input  logic        Clock,
    input  logic        Reset_n,
    imul_sched_if.slave bus
);

    localparam int IDW = idw(NREQ);
    localparam int CW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    if (SETTLE < 1) begin : g_settle_chk
        $error("imul_sched: SETTLE must be >= 1");
    end
    if (NREQ < 2 || NREQ > MAX_NREQ) begin : g_nreq_chk
        $error("imul_sched: NREQ out of range 2..8");
    end

    state_t            state;
    state_t            nstate;
    logic [CW-1:0]     cnt;
    logic [IMUL_W-1:0] op_a;
    logic [IMUL_W-1:0] op_b;
    logic [IMUL_W-1:0] sel_a;
    logic [IMUL_W-1:0] sel_b;
    logic [IDW-1:0]    id;
    logic [IDW-1:0]    gidx;
    logic [IDW-1:0]    rsp_id;
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] rsp_data;
    logic [NREQ-1:0]   gnt;
    logic              en;
    logic              accept;

    // Reset gates the grant so req_ready is low while held in reset.
    assign en     = (state == IDLE) && Reset_n;
    assign accept = |(bus.req_valid & gnt);

    imul_sched_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .req_valid (bus.req_valid),
        .en        (en),
        .accept    (accept),
        .gnt       (gnt),
        .idx       (gidx)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gidx == IDW'(i)) begin
                sel_a = bus.req_a[i*IMUL_W +: IMUL_W];
                sel_b = bus.req_b[i*IMUL_W +: IMUL_W];
            end
        end
    end

    // Array inputs come straight from op_a/op_b registers only.
    IMUL u_imul (
        .A (op_a),
        .B (op_b),
        .O (prod)
    );

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:    if (accept) nstate = RUN;
            RUN:     if (cnt == '0) nstate = RESP;
            RESP:    if (bus.rsp_ready) nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            op_a     <= '0;
            op_b     <= '0;
            id       <= '0;
            rsp_data <= '0;
            rsp_id   <= '0;
        end else begin
            state <= nstate;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_a <= sel_a;
                        op_b <= sel_b;
                        id   <= gidx;
                        cnt  <= CW'(SETTLE-1);
                    end
                end
                RUN: begin
                    if (cnt == '0) begin
                        rsp_data <= prod;
                        rsp_id   <= id;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = gnt;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_id    = rsp_id;
    assign bus.rsp_data  = rsp_data;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_imul_sched.sv
// Directed bench for imul_sched with an expected-response queue.
// Grant-order model follows IMUL_SCHED_RR_EN when defined.
module tb_imul_sched;
    import imul_sched_pkg::*;

    localparam int NREQ   = 2;
    localparam int SETTLE = 3;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          last_g = NREQ - 1;
    int          c;
    logic        bad;
    logic [32:0] sb[$];

    imul_sched_if #(.NREQ(NREQ)) bus ();

    imul_sched #(
        .NREQ   (NREQ),
        .SETTLE (SETTLE)
    ) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int i, input logic [15:0] a,
                         input logic [15:0] b);
        bus.req_a[16*i +: 16] = a;
        bus.req_b[16*i +: 16] = b;
    endtask

    task automatic push(input int i, input logic [31:0] p);
        logic id1;
        id1 = (i != 0);
        sb.push_back({id1, p});
    endtask

    function automatic int next_g();
`ifdef IMUL_SCHED_RR_EN
        return (last_g + 1) % NREQ;
`else
        return 0;
`endif
    endfunction

    task automatic wait_rsp(output int n);
        n = 0;
        do begin
            @(posedge Clock);
            @(negedge Clock);
            n++;
        end while (!bus.rsp_valid && n < 64);
        chk("rsp_wait", bus.rsp_valid, 1);
    endtask

    task automatic take(input string tag);
        logic [32:0] e;
        chk("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk(tag, {bus.rsp_id, bus.rsp_data}, e);
        end
    endtask

    task automatic finish_rsp(input string tag);
        @(posedge Clock);
        @(negedge Clock);
        chk(tag, bus.busy, 0);
    endtask

    task automatic single(input int i, input logic [15:0] a,
                          input logic [15:0] b, input logic [31:0] p,
                          input string tag);
        int n;
        drive(i, a, b);
        push(i, p);
        bus.req_valid = NREQ'(1) << i;
        #1 chk({tag, "_ready"}, bus.req_ready, NREQ'(1) << i);
        @(posedge Clock);
        @(negedge Clock);
        bus.req_valid = '0;
        last_g = i;
        wait_rsp(n);
        chk({tag, "_lat"}, n, SETTLE);
        take(tag);
        finish_rsp({tag, "_idle"});
    endtask

    initial begin
        int g;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b1;

        repeat (2) @(negedge Clock);
        bus.req_valid = 2'b11;
        #1 chk("reset_state", {bus.rsp_valid, bus.busy, bus.req_ready,
                               bus.rsp_id, bus.rsp_data}, 0);
        bus.req_valid = '0;
        @(negedge Clock);
        Reset_n = 1'b1;
        @(negedge Clock);

        single(0, 16'd3, 16'd5, 32'd15, "mul_3x5");
        single(1, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, "mul_max");
        single(0, 16'h0000, 16'h1234, 32'h0, "mul_zero");
        single(1, 16'h8000, 16'h0002, 32'h00010000, "mul_msb");

        // Both requesters held valid continuously.
        drive(0, 16'd7, 16'd9);
        drive(1, 16'd11, 16'd13);
        for (int r = 0; r < 4; r++) begin
            g = next_g();
            last_g = g;
            push(g, (g == 1) ? 32'd143 : 32'd63);
        end
        bus.req_valid = 2'b11;
        for (int r = 0; r < 4; r++) begin
            wait_rsp(c);
            take("cont_rsp");
            if (r > 0)
                chk("cont_period", c, SETTLE + 2);
        end
        bus.req_valid = '0;
        finish_rsp("cont_idle");

        // Response backpressure.
        drive(1, 16'h1234, 16'h0010);
        drive(0, 16'd6, 16'd7);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 2'b10;
        #1 chk("bp_ready", bus.req_ready, 2'b10);
        @(posedge Clock);
        @(negedge Clock);
        bus.req_valid = '0;
        push(1, 32'h00012340);
        last_g = 1;
        wait_rsp(c);
        chk("bp_lat", c, SETTLE);
        take("bp_rsp");
        bus.req_valid = 2'b11;
        for (int k = 0; k < 5; k++) begin
            @(posedge Clock);
            @(negedge Clock);
            chk("bp_hold", {bus.busy, bus.req_ready, bus.rsp_valid,
                            bus.rsp_id, bus.rsp_data},
                {1'b1, 2'b00, 1'b1, 1'b1, 32'h00012340});
        end
        bus.rsp_ready = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        g = next_g();
        chk("bp_regrant", {bus.busy, bus.req_ready},
            {1'b0, NREQ'(1) << g});
        push(g, (g == 1) ? 32'h00012340 : 32'd42);
        last_g = g;
        @(posedge Clock);
        @(negedge Clock);
        bus.req_valid = '0;
        chk("bp_busy", bus.busy, 1);
        wait_rsp(c);
        take("bp_next_rsp");
        finish_rsp("bp_idle");

        // Reset while RUN has counter = 1.
        drive(0, 16'd100, 16'd100);
        bus.req_valid = 2'b01;
        @(posedge Clock);
        @(negedge Clock);
        bus.req_valid = '0;
        @(posedge Clock);
        @(negedge Clock);
        Reset_n = 1'b0;
        bus.req_valid = 2'b11;
        #1 chk("rst_run", {bus.rsp_valid, bus.busy, bus.req_ready,
                           bus.rsp_id, bus.rsp_data}, 0);
        bus.req_valid = '0;
        last_g = NREQ - 1;
        @(negedge Clock);
        Reset_n = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge Clock);
            bad = bad | bus.rsp_valid | bus.busy;
        end
        chk("rst_quiet", bad, 0);

        // Operands must be the ones latched at acceptance.
        drive(0, 16'h00FF, 16'h0101);
        drive(1, 16'h0003, 16'h0003);
        bus.req_valid = 2'b11;
        g = next_g();
        #1 chk("rst_ptr_ready", bus.req_ready, NREQ'(1) << 0);
        push(g, (g == 1) ? 32'd9 : 32'h0000FFFF);
        last_g = g;
        @(posedge Clock);
        @(negedge Clock);
        drive(0, 16'hAAAA, 16'h5555);
        drive(1, 16'h7777, 16'h1111);
        bus.req_valid = '0;
        wait_rsp(c);
        chk("stab_lat", c, SETTLE);
        take("stab_rsp");
        finish_rsp("stab_idle");
        chk("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
